cw_encoder_top: RTL and testbench
=================================

# cw_encoder_top

Serial-to-constant-weight encoder: the transmit-side counterpart of the codeword decoder path. It accepts a binary message one bit per cycle, packs MSG_W bits, maps each group to a CW_W-bit word of Hamming weight exactly CW_T by enumerative (combinatorial-rank) encoding, and presents each codeword on a valid/ready output that feeds the 20-bit codeword FIFO. One `start` produces NUM_CW codewords and then a single-cycle `done`.

## Interface
- CW_W, 20, codeword width n
- CW_T, 8, codeword weight t
- MSG_W, 16, message bits per codeword; requires 2^MSG_W ≤ C(CW_W,CW_T), i.e. 65536 ≤ 125970
- NUM_CW, 10, codewords per message
- clk  in  1  single clock, rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a message; sampled only in IDLE
- bin_msg  in  1  serial message bit, MSB of each group first
- bin_vld  in  1  bin_msg valid
- bin_rdy  out  1  encoder accepts a bit this cycle
- cw_word  out  CW_W  encoded codeword
- cw_vld  out  1  cw_word valid
- cw_rdy  in  1  downstream accepts cw_word (FIFO not full)
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the NUM_CW-th codeword is accepted

## Operation
- States: IDLE, LOAD, ENC, OUT.
- IDLE: `start`=1 sets cw_cnt=0 and moves to LOAD.
- LOAD: bin_rdy=1. On each bin_vld&bin_rdy edge, val <= {val[MSG_W-2:0], bin_msg}, bit_cnt++. On acceptance of bit MSG_W-1: pos=CW_W-1, k=CW_T, word=0, go to ENC.
- ENC: one position per cycle, pos = CW_W-1 down to 0.
  - Binomial ROM C(i,j) for i<CW_W, j≤CW_T, with C(i,j)=0 when j>i and C(i,0)=1.
  - If k>0 and val ≥ C(pos,k): word[pos]=1, val -= C(pos,k), k--. Else word[pos]=0.
  - val register is 17 bits wide (ranks up to 125969). ROM entries are 17 bits wide.
  - After pos=0 is processed, go to OUT.
- The output weight is always exactly CW_T. Bench checks this invariant on every codeword.
- OUT: cw_vld=1, cw_word=word. On cw_rdy: cw_cnt++. If cw_cnt reaches NUM_CW, pulse done and go to IDLE. Otherwise clear bit_cnt and go to LOAD.
- `start` outside IDLE is ignored. bin_vld outside LOAD is ignored; no bit is consumed.

## Timing
- Reset values: bin_rdy=0, cw_vld=0, cw_word=0, busy=0, done=0. State=IDLE, all counters=0.
- Reset asserted mid-operation returns to IDLE on that edge. The partial codeword is discarded and no `done` is issued.
- `start` sampled at edge E: bin_rdy is high from cycle E+1.
- Latency: cw_vld rises exactly CW_W cycles (20) after the edge that accepts the last message bit.
- Per-codeword throughput with no stalls: MSG_W + CW_W + 1 cycles (37).
- While cw_vld=1 and cw_rdy=0, cw_word holds stable and no input bits are accepted.
- cw_vld falls on the edge after a cw_rdy handshake. done is high in the cycle after the final handshake, and busy is low in that same cycle.
- A `start` in the cycle done is high is accepted, since the block is in IDLE.
- bin_vld gaps in LOAD stall bit collection with no loss. bit_cnt advances only on a handshake.

## Test plan
- Message 0x0000 -> cw_word=20'h000FF. Check latency: 20 cycles from the last bit to cw_vld.
- Message 0x0001 -> cw_word=20'h0017F. Message 0x0002 -> cw_word=20'h001BF.
- 10 groups of random messages with cw_rdy held at 1 -> exactly 10 handshakes, each with weight 8. All words are distinct for distinct inputs. done pulses once, 1 cycle wide.
- cw_rdy held low for 5 cycles in OUT -> cw_word stable, bin_rdy=0, no bit consumed. Resume gives the correct next codeword.
- rst pulsed during ENC of codeword 3 -> all outputs 0 the next cycle. A new `start` then yields a correct full sequence of 10 codewords.
- bin_vld toggled 50% random, and `start` asserted while busy -> results identical to the no-gap run, and the extra `start` has no effect.

Source files
------------

// File: rtl/cw_encoder_top_if.sv
// Handshake bundle for the constant-weight encoder: serial message bits in,
// codewords out on a valid/ready channel.
interface cw_encoder_top_if #(
  parameter int unsigned CW_W = 20
) ();
  logic            bin_msg;
  logic            bin_vld;
  logic            bin_rdy;
  logic [CW_W-1:0] cw_word;
  logic            cw_vld;
  logic            cw_rdy;

  modport master (
    output bin_msg, bin_vld, cw_rdy,
    input  bin_rdy, cw_word, cw_vld
  );

  modport slave (
    input  bin_msg, bin_vld, cw_rdy,
    output bin_rdy, cw_word, cw_vld
  );
endinterface

// File: rtl/cw_encoder_top.sv
// Serial-to-constant-weight encoder: packs MSG_W message bits and unranks them
// into a CW_W-bit word of weight CW_T, one position per cycle.
module cw_encoder_top #(
  parameter int unsigned CW_W   = 20,
  parameter int unsigned CW_T   = 8,
  parameter int unsigned MSG_W  = 16,
  parameter int unsigned NUM_CW = 10
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  cw_encoder_top_if.slave     cw_bus,
  output logic                o_busy,
  output logic                o_done
);

  localparam int unsigned VAL_W = 17;
  localparam int unsigned POS_W = $clog2(CW_W);
  localparam int unsigned K_W   = $clog2(CW_T + 1);
  localparam int unsigned BIT_W = $clog2(MSG_W + 1);
  localparam int unsigned CNT_W = $clog2(NUM_CW + 1);

  typedef logic [CW_W-1:0][CW_T:0][VAL_W-1:0] rom_t;

  // Pascal's triangle, evaluated at elaboration into a constant table.
  function automatic rom_t gen_rom();
    rom_t rom;
    rom = '0;
    for (int i = 0; i < int'(CW_W); i++) begin
      for (int j = 0; j <= int'(CW_T); j++) begin
        if (j == 0) begin
          rom[i][j] = VAL_W'(1);
        end else if (j > i) begin
          rom[i][j] = '0;
        end else begin
          rom[i][j] = rom[i-1][j-1] + rom[i-1][j];
        end
      end
    end
    return rom;
  endfunction

  localparam rom_t BinomRom = gen_rom();

  typedef enum logic [1:0] {StIdle, StLoad, StEnc, StOut} state_e;

  state_e            r_state;
  state_e            w_state_next;
  logic [VAL_W-1:0]  r_val;
  logic [CW_W-1:0]   r_word;
  logic [POS_W-1:0]  r_pos;
  logic [K_W-1:0]    r_k;
  logic [BIT_W-1:0]  r_bit_cnt;
  logic [CNT_W-1:0]  r_cw_cnt;
  logic              r_done;

  logic              w_last_bit;
  logic              w_last_cw;
  logic [VAL_W-1:0]  w_binom;
  logic              w_take;

  assign w_last_bit = (r_bit_cnt == BIT_W'(MSG_W - 1));
  assign w_last_cw  = (r_cw_cnt == CNT_W'(NUM_CW - 1));
  assign w_binom    = BinomRom[r_pos][r_k];
  assign w_take     = (r_k != '0) && (r_val >= w_binom);

  always_comb begin
    w_state_next   = r_state;
    cw_bus.bin_rdy = 1'b0;
    cw_bus.cw_vld  = 1'b0;
    cw_bus.cw_word = '0;
    unique case (r_state)
      StIdle: if (i_start) w_state_next = StLoad;
      StLoad: begin
        cw_bus.bin_rdy = 1'b1;
        if (cw_bus.bin_vld && w_last_bit) w_state_next = StEnc;
      end
      StEnc: if (r_pos == '0) w_state_next = StOut;
      StOut: begin
        cw_bus.cw_vld  = 1'b1;
        cw_bus.cw_word = r_word;
        if (cw_bus.cw_rdy) w_state_next = w_last_cw ? StIdle : StLoad;
      end
      default: w_state_next = StIdle;
    endcase
  end

  assign o_busy = (r_state != StIdle);
  assign o_done = r_done;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= StIdle;
      r_val     <= '0;
      r_word    <= '0;
      r_pos     <= '0;
      r_k       <= '0;
      r_bit_cnt <= '0;
      r_cw_cnt  <= '0;
      r_done    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (i_start) begin
            r_cw_cnt  <= '0;
            r_bit_cnt <= '0;
            r_val     <= '0;
          end
        end
        StLoad: begin
          if (cw_bus.bin_vld) begin
            r_val     <= {r_val[VAL_W-2:0], cw_bus.bin_msg};
            r_bit_cnt <= r_bit_cnt + BIT_W'(1);
            if (w_last_bit) begin
              r_pos  <= POS_W'(CW_W - 1);
              r_k    <= K_W'(CW_T);
              r_word <= '0;
            end
          end
        end
        StEnc: begin
          // Greedy unranking: take this position when the remaining rank covers
          // every weight-k pattern confined to the lower positions.
          if (w_take) begin
            r_word[r_pos] <= 1'b1;
            r_val         <= r_val - w_binom;
            r_k           <= r_k - K_W'(1);
          end
          r_pos <= r_pos - POS_W'(1);
        end
        StOut: begin
          if (cw_bus.cw_rdy) begin
            r_cw_cnt <= r_cw_cnt + CNT_W'(1);
            if (w_last_cw) begin
              r_done <= 1'b1;
            end else begin
              r_bit_cnt <= '0;
              r_val     <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cw_encoder_top.sv
// Randomized bench for cw_encoder_top against an arithmetic unranking model.
module tb_cw_encoder_top;
  localparam int CW_W   = 20;
  localparam int CW_T   = 8;
  localparam int MSG_W  = 16;
  localparam int NUM_CW = 10;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic busy;
  logic done;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int done_cnt = 0;

  logic [MSG_W-1:0] msgs [NUM_CW];
  logic [CW_W-1:0]  got  [NUM_CW];
  logic [CW_W-1:0]  ref_got [NUM_CW];

  always #5 clk = ~clk;

  cw_encoder_top_if #(.CW_W(CW_W)) bus ();

  cw_encoder_top #(
    .CW_W  (CW_W),
    .CW_T  (CW_T),
    .MSG_W (MSG_W),
    .NUM_CW(NUM_CW)
  ) dut (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_start(start),
    .cw_bus (bus),
    .o_busy (busy),
    .o_done (done)
  );

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic longint choose(int n, int k);
    longint r;
    if (k < 0 || k > n) return 0;
    r = 1;
    for (int i = 0; i < k; i++) r = r * (n - i) / (i + 1);
    return r;
  endfunction

  // The word of rank msg among weight-CW_T words, in colex order from the MSB.
  function automatic logic [CW_W-1:0] model_word(int msg);
    longint rank;
    int k;
    logic [CW_W-1:0] w;
    rank = msg;
    k = CW_T;
    w = '0;
    for (int pos = CW_W - 1; pos >= 0; pos--) begin
      if (k > 0 && rank >= choose(pos, k)) begin
        w[pos] = 1'b1;
        rank -= choose(pos, k);
        k--;
      end
    end
    return w;
  endfunction

  task automatic rand_msgs();
    for (int i = 0; i < NUM_CW; i++) msgs[i] = MSG_W'($urandom_range(0, 65535));
  endtask

  task automatic run_seq(input bit gaps, input int stall_idx, input bit extra_start,
                         input int abort_idx, input bit check_tput);
    int last_hs;
    int dc0;
    dc0 = done_cnt;
    last_hs = -1;
    start = 1'b1;
    tick();
    start = 1'b0;
    check_eq("rdy_after_start", bus.bin_rdy, 1);
    for (int c = 0; c < NUM_CW; c++) begin
      int b;
      int guard;
      int lat;
      b = MSG_W - 1;
      guard = 0;
      while (b >= 0 && guard < 1000) begin
        logic v;
        logic acc;
        v = gaps ? logic'($urandom_range(0, 1)) : 1'b1;
        bus.bin_vld = v;
        bus.bin_msg = msgs[c][b];
        acc = v && bus.bin_rdy;
        tick();
        guard++;
        if (acc) b--;
      end
      check_eq("load_bits_left", b + 1, 0);
      lat = 0;
      while (!bus.cw_vld && lat < 100) begin
        bus.bin_vld = logic'($urandom_range(0, 1));
        bus.bin_msg = logic'($urandom_range(0, 1));
        start = extra_start && (lat == 3);
        if (c == abort_idx && lat == 5) begin
          rst = 1'b1;
          tick();
          rst = 1'b0;
          start = 1'b0;
          bus.bin_vld = 1'b0;
          check_eq("rst_bin_rdy", bus.bin_rdy, 0);
          check_eq("rst_cw_vld", bus.cw_vld, 0);
          check_eq("rst_cw_word", bus.cw_word, 0);
          check_eq("rst_busy", busy, 0);
          check_eq("rst_done", done, 0);
          for (int i = 0; i < 3; i++) tick();
          check_eq("rst_stays_idle", busy, 0);
          check_eq("rst_no_done", done_cnt - dc0, 0);
          return;
        end
        tick();
        lat++;
      end
      start = 1'b0;
      check_eq("latency", lat, CW_W);
      if (c == stall_idx) begin
        logic [CW_W-1:0] w0;
        bus.cw_rdy = 1'b0;
        bus.bin_vld = 1'b1;
        w0 = bus.cw_word;
        for (int i = 0; i < 5; i++) begin
          tick();
          check_eq("stall_word", bus.cw_word, w0);
          check_eq("stall_bin_rdy", bus.bin_rdy, 0);
          check_eq("stall_vld", bus.cw_vld, 1);
        end
        bus.cw_rdy = 1'b1;
      end
      check_eq($sformatf("cw%0d", c), bus.cw_word, model_word(int'(msgs[c])));
      check_eq("weight", $countones(bus.cw_word), CW_T);
      got[c] = bus.cw_word;
      bus.bin_vld = 1'b0;
      tick();
      if (check_tput && last_hs >= 0) check_eq("throughput", cyc - last_hs, MSG_W + CW_W + 1);
      last_hs = cyc;
      check_eq("vld_fall", bus.cw_vld, 0);
      if (c == NUM_CW - 1) begin
        check_eq("done_high", done, 1);
        check_eq("busy_low_at_done", busy, 0);
        tick();
        check_eq("done_one_cycle", done, 0);
      end else begin
        check_eq("done_early", done, 0);
        check_eq("next_load", bus.bin_rdy, 1);
      end
    end
    check_eq("done_count", done_cnt - dc0, 1);
  endtask

  task automatic check_distinct();
    int coll;
    coll = 0;
    for (int i = 0; i < NUM_CW; i++)
      for (int j = i + 1; j < NUM_CW; j++)
        if (msgs[i] != msgs[j] && got[i] == got[j]) coll++;
    check_eq("distinct", coll, 0);
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    bus.bin_vld = 1'b0;
    bus.bin_msg = 1'b0;
    bus.cw_rdy = 1'b1;
    tick();
    tick();
    check_eq("reset_bin_rdy", bus.bin_rdy, 0);
    check_eq("reset_cw_vld", bus.cw_vld, 0);
    check_eq("reset_cw_word", bus.cw_word, 0);
    check_eq("reset_busy", busy, 0);
    check_eq("reset_done", done, 0);
    rst = 1'b0;
    bus.bin_vld = 1'b1;
    tick();
    check_eq("idle_ignores_bits", bus.bin_rdy, 0);

    // Directed messages with known codewords, no stalls.
    rand_msgs();
    msgs[0] = 16'h0000;
    msgs[1] = 16'h0001;
    msgs[2] = 16'h0002;
    msgs[3] = 16'hFFFF;
    run_seq(1'b0, -1, 1'b0, -1, 1'b1);
    check_eq("known_0000", got[0], 20'h000FF);
    check_eq("known_0001", got[1], 20'h0017F);
    check_eq("known_0002", got[2], 20'h001BF);
    check_distinct();

    // Random run with a 5-cycle output stall.
    rand_msgs();
    run_seq(1'b0, 4, 1'b0, -1, 1'b0);
    check_distinct();

    // Reset during encoding of codeword 3, then a full clean run.
    rand_msgs();
    run_seq(1'b0, -1, 1'b0, 3, 1'b0);
    run_seq(1'b0, -1, 1'b0, -1, 1'b1);
    check_distinct();
    for (int i = 0; i < NUM_CW; i++) ref_got[i] = got[i];

    // Same messages with random bin_vld gaps and a stray start while busy.
    run_seq(1'b1, -1, 1'b1, -1, 1'b0);
    for (int i = 0; i < NUM_CW; i++) check_eq($sformatf("gap_same%0d", i), got[i], ref_got[i]);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
